// File: rtl/freq_medidor.sv
// freq_medidor: receives a slow asynchronous clock into the reloje domain, pulses tick on each rise,
// measures the period and flags loss of signal. Define FREQ_MEDIDOR_MINMAX_EN to add periodo_min/periodo_max.
module freq_medidor #(
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_W       = 32,
  parameter longint unsigned  TIMEOUT     = 64'd3_100_000_000
) (
  input  logic             reloje,
  input  logic             reset,
  input  logic             relojs_in,
  output logic             tick,
  output logic [CNT_W-1:0] periodo,
  output logic             valido,
`ifdef FREQ_MEDIDOR_MINMAX_EN
  output logic             perdida,
  output logic [CNT_W-1:0] periodo_min,
  output logic [CNT_W-1:0] periodo_max
`else
  output logic             perdida
`endif
);

  localparam logic [CNT_W-1:0] TOPE = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] UNO  = CNT_W'(1);

  typedef enum logic [1:0] {
    ESPERA,
    MIDIENDO,
    PERDIDA
  } estado_t;

  estado_t estado_q, estado_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sube;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] periodo_d;
  logic             valido_d;
  logic             perdida_d;

  // Stages and history load 1 so that a level already high at reset release never looks like a rise.
  always_ff @(posedge reloje) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], relojs_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sube = sync_q[SYNC_STAGES-1] & ~hist_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge reloje) begin
    if (reset) begin
      estado_q <= ESPERA;
      cnt_q    <= '0;
      tick     <= 1'b0;
      periodo  <= '0;
      valido   <= 1'b0;
      perdida  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      tick     <= sube;
      periodo  <= periodo_d;
      valido   <= valido_d;
      perdida  <= perdida_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA:   if (sube) estado_d = MIDIENDO;
      MIDIENDO: if (!sube && cnt_q == TOPE) estado_d = PERDIDA;
      PERDIDA:  if (sube) estado_d = MIDIENDO;
      default:  estado_d = ESPERA;
    endcase
  end

  // A rise always wins over the timeout, so a period of exactly TOPE is still reported.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    cnt_d     = cnt_q;
    periodo_d = periodo;
    valido_d  = valido;
    perdida_d = perdida;
    case (estado_q)
      ESPERA: begin
        if (sube) cnt_d = UNO;
      end
      MIDIENDO: begin
        if (sube) begin
          periodo_d = cnt_q;
          valido_d  = 1'b1;
          cnt_d     = UNO;
        end else if (cnt_q == TOPE) begin
          perdida_d = 1'b1;
          valido_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + UNO;
        end
      end
      PERDIDA: begin
        if (sube) begin
          perdida_d = 1'b0;
          cnt_d     = UNO;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

`ifdef FREQ_MEDIDOR_MINMAX_EN
  logic             medida;
  logic             recarga_q, recarga_d;
  logic [CNT_W-1:0] min_d, max_d;

  assign medida = (estado_q == MIDIENDO) && sube;

  // After a loss the first new period replaces both extremes instead of merging with stale history.
  always_comb begin
    min_d     = periodo_min;
    max_d     = periodo_max;
    recarga_d = recarga_q;
    if (medida) begin
      if (recarga_q) begin
        min_d     = cnt_q;
        max_d     = cnt_q;
        recarga_d = 1'b0;
      end else begin
        if (cnt_q < periodo_min) min_d = cnt_q;
        if (cnt_q > periodo_max) max_d = cnt_q;
      end
    end else if (estado_q == MIDIENDO && cnt_q == TOPE) begin
      recarga_d = 1'b1;
    end
  end

  always_ff @(posedge reloje) begin
    if (reset) begin
      periodo_min <= '1;
      periodo_max <= '0;
      recarga_q   <= 1'b0;
    end else begin
      periodo_min <= min_d;
      periodo_max <= max_d;
      recarga_q   <= recarga_d;
    end
  end
`endif

endmodule

// File: tb/tb_freq_medidor.sv
// tb_freq_medidor: directed square-wave stimulus with a scoreboard of expected outputs per rise.
// Min/max checks run only when FREQ_MEDIDOR_MINMAX_EN is defined.
module tb_freq_medidor;

  localparam int SS = 2;
  localparam int W  = 8;
  localparam int TO = 20;

  logic         reloje    = 1'b0;
  logic         reset     = 1'b1;
  logic         relojs_in = 1'b1;
  logic         tick;
  logic [W-1:0] periodo;
  logic         valido;
  logic         perdida;
`ifdef FREQ_MEDIDOR_MINMAX_EN
  logic [W-1:0] periodo_min;
  logic [W-1:0] periodo_max;
`endif

  typedef struct {
    logic [W-1:0] periodo;
    logic         valido;
    logic         perdida;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  freq_medidor #(
    .SYNC_STAGES(SS),
    .CNT_W      (W),
    .TIMEOUT    (TO)
  ) dut (
    .reloje     (reloje),
    .reset      (reset),
    .relojs_in  (relojs_in),
    .tick       (tick),
    .periodo    (periodo),
    .valido     (valido),
`ifdef FREQ_MEDIDOR_MINMAX_EN
    .perdida    (perdida),
    .periodo_min(periodo_min),
    .periodo_max(periodo_max)
`else
    .perdida    (perdida)
`endif
  );

  always #5 reloje = ~reloje;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge reloje);
    #1;
  endtask

  // One input cycle: h samples high then l samples low; tick must appear exactly SS+1 edges after the rise.
  task automatic pulse(input int h, input int l, input logic [W-1:0] ep, input logic ev, input logic epd);
    exp_t e;
    exp_q.push_back('{ep, ev, epd});
    relojs_in = 1'b1;
    for (int i = 1; i <= h + l; i++) begin
      cyc(1);
      if (i == h) relojs_in = 1'b0;
      if (i == SS + 1) begin
        check("tick_rise", tick, 1);
        e = exp_q.pop_front();
        check("periodo", periodo, e.periodo);
        check("valido", valido, e.valido);
        check("perdida", perdida, e.perdida);
      end else begin
        check("tick_idle", tick, 0);
      end
    end
  endtask

  initial begin
    // 1: high input through reset and after release never ticks
    reset     = 1'b1;
    relojs_in = 1'b1;
    cyc(3);
    check("rst_tick", tick, 0);
    check("rst_periodo", periodo, 0);
    check("rst_valido", valido, 0);
    check("rst_perdida", perdida, 0);
`ifdef FREQ_MEDIDOR_MINMAX_EN
    check("rst_min", periodo_min, 8'hFF);
    check("rst_max", periodo_max, 0);
`endif
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      check("high_no_tick", tick, 0);
    end
    check("high_periodo", periodo, 0);
    check("high_valido", valido, 0);
    check("high_perdida", perdida, 0);

    // 2: period 10 square wave from low
    relojs_in = 1'b0;
    cyc(5);
    pulse(5, 5, 0, 0, 0);
    pulse(5, 5, 10, 1, 0);
    pulse(5, 5, 10, 1, 0);

    // 3: rise then held low until loss
    pulse(5, 17, 10, 1, 0);
    check("loss_pre_perdida", perdida, 0);
    check("loss_pre_valido", valido, 1);
    cyc(1);
    check("loss_perdida", perdida, 1);
    check("loss_valido", valido, 0);
    check("loss_periodo", periodo, 10);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("loss_no_tick", tick, 0);
      check("loss_hold", perdida, 1);
    end

    // 4: recovery with period 6
    pulse(3, 3, 10, 0, 0);
    pulse(3, 3, 6, 1, 0);

    // 5: period exactly TIMEOUT, then reset mid-period
    pulse(10, 10, 6, 1, 0);
    pulse(3, 5, TO, 1, 0);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_tick", tick, 0);
    check("mid_rst_periodo", periodo, 0);
    check("mid_rst_valido", valido, 0);
    check("mid_rst_perdida", perdida, 0);
    cyc(1);
    reset = 1'b0;
    cyc(4);
    pulse(3, 3, 0, 0, 0);
    pulse(3, 3, 6, 1, 0);

    // 6: periods 10, 6, 14, loss, then 8 twice
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    pulse(5, 5, 0, 0, 0);
    pulse(3, 3, 10, 1, 0);
    pulse(7, 7, 6, 1, 0);
    pulse(3, 25, 14, 1, 0);
    check("mm_loss", perdida, 1);
`ifdef FREQ_MEDIDOR_MINMAX_EN
    check("mm_min", periodo_min, 6);
    check("mm_max", periodo_max, 14);
`endif
    pulse(4, 4, 14, 0, 0);
    pulse(4, 4, 8, 1, 0);
`ifdef FREQ_MEDIDOR_MINMAX_EN
    check("mm_reload_min", periodo_min, 8);
    check("mm_reload_max", periodo_max, 8);
`endif
    pulse(4, 4, 8, 1, 0);
`ifdef FREQ_MEDIDOR_MINMAX_EN
    check("mm_final_min", periodo_min, 8);
    check("mm_final_max", periodo_max, 8);
`endif
    cyc(2);
    check("sb_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_medidor.md
Name: freq_medidor

Overview:
- Receiver/measurement end of the divided-clock path.
- Takes a slow, asynchronous square-wave clock produced by a divider stage and synchronizes it into the fast `reloje` domain.
- Emits a one-cycle pulse per rising edge and measures the period in `reloje` cycles.
- Flags loss of signal when no edge arrives within a timeout.
- Used by the alarm-clock logic to consume and supervise divided clocks.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on `relojs_in` (legal values ≥ 2).
- CNT_W, 32: width of the period counter and of `periodo`.
- TIMEOUT, 3_100_000_000: number of cycles without a rising edge before loss is flagged; must be ≤ 2^CNT_W−1.

Ports:
- reloje, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- relojs_in, input, 1: asynchronous slow clock being received.
- tick, output, 1: one-cycle pulse per detected rising edge of `relojs_in`.
- periodo, output, CNT_W: last measured period, in `reloje` cycles.
- valido, output, 1: `periodo` holds a measurement taken since the last reset or loss.
- perdida, output, 1: loss of signal, meaning no edge for TIMEOUT cycles.

Behaviour:
- Reset (sampled on `reloje` rising edge while `reset`=1):
  - All synchronizer stages and the edge-history flop load 1, so a rise is only detected after a 0 has been seen. A high input at reset release therefore gives no tick.
  - `cnt` = 0; state = ESPERA.
  - tick = 0, periodo = 0, valido = 0, perdida = 0.
  - Reset mid-measurement discards `cnt` and all outputs on the next edge.
- Edge detect:
  - `sube` = last sync stage & ~history flop; the history flop follows the last sync stage every cycle.
  - `tick` is a registered copy of `sube`. Latency from the first sampling edge that sees `relojs_in`=1 to `tick`=1 is SYNC_STAGES+1 cycles.
  - `tick` is exactly 1 cycle wide.
- Counter:
  - On a cycle with `sube`: `cnt` <= 1.
  - Otherwise, in MIDIENDO: `cnt` <= `cnt`+1.
  - `cnt` never wraps, because the TIMEOUT bound guarantees this.
- FSM:
  - ESPERA: waiting for the first rise. On `sube`: go to MIDIENDO, `cnt`<=1, no period is output.
  - MIDIENDO:
    - On `sube`: `periodo`<=`cnt`, `valido`<=1, `cnt`<=1.
    - Else if `cnt`==TIMEOUT: go to PERDIDA, `perdida`<=1, `valido`<=0, `periodo` holds its value.
  - PERDIDA: `cnt` frozen. On `sube`: go to MIDIENDO, `perdida`<=0, `cnt`<=1. `valido` stays 0 until the next complete period.
- Simultaneous events: `sube` in the same cycle as `cnt`==TIMEOUT means the edge wins. A period equal to TIMEOUT is reported as valid.
- Output timing: `tick`, `periodo`, `valido` and `perdida` are all registered outputs, updated on the same edge as the state change.
- Input assumption: the minimum input high or low time is ≥ SYNC_STAGES+1 cycles. Narrower pulses may be missed, and that is acceptable.

Optional Feature:
- FREQ_MEDIDOR_MINMAX_EN defined:
  - Adds outputs `periodo_min` [CNT_W] and `periodo_max` [CNT_W].
  - Both update on every valid measurement (min/max of all measured periods).
  - Both reset to all-ones and 0 respectively.
  - Both are reloaded from the first measurement after entering PERDIDA.
- Undefined: those ports and their registers do not exist; all other behaviour is identical.

Test Plan (SYNC_STAGES=2, CNT_W=8, TIMEOUT=20 unless stated):
1. Hold `relojs_in`=1 through reset and for 30 cycles after release -> `tick` never asserts; periodo=0, valido=0, perdida=0.
2. Square wave with period 10 (5 high/5 low) from low -> first rise gives tick one cycle wide, 3 cycles after the sampling edge, valido=0. Second rise gives periodo=10, valido=1. Each later rise gives periodo=10.
3. After a rise, hold the input low -> perdida=1 on the cycle after cnt reaches 20; valido=0; periodo stays 10; no tick.
4. From PERDIDA, apply period 6 -> first rise clears perdida with valido still 0. Next rise gives periodo=6, valido=1.
5. Rise arriving exactly when cnt==20 -> periodo=20, valido=1, perdida stays 0. Assert reset mid-period -> next cycle all outputs 0, state ESPERA.
6. FREQ_MEDIDOR_MINMAX_EN defined; periods 10, 6, 14 -> periodo_min=6, periodo_max=14. After a loss followed by period 8 twice -> min=8, max=8.
